// File: rtl/canny_pkg.sv
// Shared constants for the Canny edge pipeline: direction thresholds (Q8),
// gradient sector codes and the default gradient width.
package canny_pkg;

    localparam int GW_DEF   = 12;
    localparam int TAN22_Q8 = 106;
    localparam int TAN67_Q8 = 618;

    typedef enum logic [1:0] {
        DIR_H    = 2'd0,
        DIR_D45  = 2'd1,
        DIR_V    = 2'd2,
        DIR_D135 = 2'd3
    } dir_e;

endpackage

// File: rtl/grad_abs_sat.sv
// Signed-to-absolute converter; the most-negative code saturates to the
// largest positive magnitude so the result always fits in W-1 bits.
module grad_abs_sat #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] din,
    output logic [W-2:0]        dout
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] neg;

    always_comb begin
        neg  = ~din + ONE;
        dout = din[W-2:0];
        if (din == MOST_NEG) begin
            dout = '1;
        end else if (din[W-1]) begin
            dout = neg[W-2:0];
        end
    end

endmodule

// File: rtl/grad_mag_dir.sv
// Sobel gradient consumer: L1 magnitude, quantised direction and raster
// eol/eof tagging in a fixed 3-cycle pipeline. Direction logic is built only
// when GRAD_DIR_EN is defined; otherwise dir is tied to DIR_H.
module grad_mag_dir
    import canny_pkg::*;
#(
    parameter int GW    = GW_DEF,
    parameter int IMG_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pi_flag,
    input  logic signed [GW-1:0] dx,
    input  logic signed [GW-1:0] dy,
    input  logic [IMG_W-1:0]     IH,
    input  logic [IMG_W-1:0]     IW,
    output logic                 po_flag,
    output logic [GW-1:0]        mag,
    output logic [1:0]           dir,
    output logic                 po_eol,
    output logic                 po_eof
);

    localparam logic [IMG_W-1:0] THREE = IMG_W'(3);
    localparam logic [IMG_W-1:0] ONE   = IMG_W'(1);

    // ---------------- raster tracking ----------------
    logic [IMG_W-1:0] col_q, col_d, row_q, row_d;
    logic [IMG_W-1:0] iw_q, iw_d, ih_q, ih_d;
    logic [IMG_W-1:0] last_col, last_row;
    logic             frame_start, eol_now, eof_now;

    // The first pixel of a frame must use the live size inputs, otherwise a
    // 1x1 frame would be tagged with the previous frame's geometry.
    always_comb begin
        frame_start = (col_q == '0) && (row_q == '0);
        last_col    = (frame_start ? IW : iw_q) - THREE;
        last_row    = (frame_start ? IH : ih_q) - THREE;
        eol_now     = (col_q == last_col);
        eof_now     = eol_now && (row_q == last_row);
        col_d       = col_q;
        row_d       = row_q;
        iw_d        = iw_q;
        ih_d        = ih_q;
        if (pi_flag) begin
            if (frame_start) begin
                iw_d = IW;
                ih_d = IH;
            end
            if (eof_now) begin
                col_d = '0;
                row_d = '0;
            end else if (eol_now) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            iw_q  <= '0;
            ih_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            iw_q  <= iw_d;
            ih_q  <= ih_d;
        end
    end

    // ---------------- S1: absolute values, signs, position flags ----------------
    logic [GW-2:0] ax, ay;

    grad_abs_sat #(.W(GW)) u_abs_dx (.din(dx), .dout(ax));
    grad_abs_sat #(.W(GW)) u_abs_dy (.din(dy), .dout(ay));

    logic          s1_vld_q, s1_vld_d, s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
    logic [GW-2:0] s1_ax_q, s1_ax_d, s1_ay_q, s1_ay_d;

    always_comb begin
        s1_vld_d = pi_flag;
        s1_eol_d = pi_flag & eol_now;
        s1_eof_d = pi_flag & eof_now;
        s1_ax_d  = pi_flag ? ax : s1_ax_q;
        s1_ay_d  = pi_flag ? ay : s1_ay_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_eol_q <= 1'b0;
            s1_eof_q <= 1'b0;
            s1_ax_q  <= '0;
            s1_ay_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_eol_q <= s1_eol_d;
            s1_eof_q <= s1_eof_d;
            s1_ax_q  <= s1_ax_d;
            s1_ay_q  <= s1_ay_d;
        end
    end

    // ---------------- S2: magnitude sum ----------------
    logic          s2_vld_q, s2_vld_d, s2_eol_q, s2_eol_d, s2_eof_q, s2_eof_d;
    logic [GW-1:0] s2_mag_q, s2_mag_d;

    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_eol_d = s1_vld_q & s1_eol_q;
        s2_eof_d = s1_vld_q & s1_eof_q;
        s2_mag_d = s1_vld_q ? ({1'b0, s1_ax_q} + {1'b0, s1_ay_q}) : s2_mag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_eol_q <= 1'b0;
            s2_eof_q <= 1'b0;
            s2_mag_q <= '0;
        end else begin
            s2_vld_q <= s2_vld_d;
            s2_eol_q <= s2_eol_d;
            s2_eof_q <= s2_eof_d;
            s2_mag_q <= s2_mag_d;
        end
    end

    // ---------------- S3: output registers ----------------
    logic          po_flag_q, po_flag_d, po_eol_q, po_eol_d, po_eof_q, po_eof_d;
    logic [GW-1:0] mag_q, mag_d;

    always_comb begin
        po_flag_d = s2_vld_q;
        po_eol_d  = s2_vld_q & s2_eol_q;
        po_eof_d  = s2_vld_q & s2_eof_q;
        mag_d     = s2_vld_q ? s2_mag_q : mag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            po_flag_q <= 1'b0;
            po_eol_q  <= 1'b0;
            po_eof_q  <= 1'b0;
            mag_q     <= '0;
        end else begin
            po_flag_q <= po_flag_d;
            po_eol_q  <= po_eol_d;
            po_eof_q  <= po_eof_d;
            mag_q     <= mag_d;
        end
    end

    assign po_flag = po_flag_q;
    assign po_eol  = po_eol_q;
    assign po_eof  = po_eof_q;
    assign mag     = mag_q;

`ifdef GRAD_DIR_EN
    // Products kept at full width (GW-1 magnitude bits + 10 threshold bits).
    localparam int PW = GW - 1 + 10;

    logic          s1_sx_q, s1_sx_d, s1_sy_q, s1_sy_d;
    logic [PW-1:0] ay_q8, ax_t1, ax_t2;
    logic          s2_le1_q, s2_le1_d, s2_ge2_q, s2_ge2_d, s2_same_q, s2_same_d;
    dir_e          dir_q, dir_d;

    always_comb begin
        s1_sx_d   = pi_flag ? dx[GW-1] : s1_sx_q;
        s1_sy_d   = pi_flag ? dy[GW-1] : s1_sy_q;
        ay_q8     = PW'({s1_ay_q, 8'd0});
        ax_t1     = PW'(s1_ax_q) * PW'(TAN22_Q8);
        ax_t2     = PW'(s1_ax_q) * PW'(TAN67_Q8);
        s2_le1_d  = s1_vld_q ? (ay_q8 <= ax_t1) : s2_le1_q;
        s2_ge2_d  = s1_vld_q ? (ay_q8 >= ax_t2) : s2_ge2_q;
        s2_same_d = s1_vld_q ? (s1_sx_q == s1_sy_q) : s2_same_q;
        dir_d     = dir_q;
        if (s2_vld_q) begin
            if (s2_le1_q) begin
                dir_d = DIR_H;
            end else if (s2_ge2_q) begin
                dir_d = DIR_V;
            end else if (s2_same_q) begin
                dir_d = DIR_D45;
            end else begin
                dir_d = DIR_D135;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sx_q   <= 1'b0;
            s1_sy_q   <= 1'b0;
            s2_le1_q  <= 1'b0;
            s2_ge2_q  <= 1'b0;
            s2_same_q <= 1'b0;
            dir_q     <= DIR_H;
        end else begin
            s1_sx_q   <= s1_sx_d;
            s1_sy_q   <= s1_sy_d;
            s2_le1_q  <= s2_le1_d;
            s2_ge2_q  <= s2_ge2_d;
            s2_same_q <= s2_same_d;
            dir_q     <= dir_d;
        end
    end

    assign dir = dir_q;
`else
    assign dir = DIR_H;
`endif

endmodule

// File: doc/grad_mag_dir.md
# grad_mag_dir

Consumer stage for the Sobel gradient stream. Takes the `pi_flag`/`dx`/`dy` stream produced by the Sobel control stage, computes the L1 gradient magnitude and a 2-bit quantised gradient direction per pixel, and tracks raster position. The raster tracking marks line and frame ends for the non-maximum-suppression stage downstream. The block is a fixed-latency pipeline with no back-pressure.

## Interface
Parameters:
- `GW`, 12: signed gradient input width.
- `IMG_W`, 11: width of the image size inputs.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pi_flag`  in  1  gradient sample valid; one pixel per asserted cycle.
- `dx`  in  GW signed  horizontal gradient.
- `dy`  in  GW signed  vertical gradient.
- `IH`  in  IMG_W  source image height; sampled only at frame start.
- `IW`  in  IMG_W  source image width; sampled only at frame start.
- `po_flag`  out  1  output valid.
- `mag`  out  GW unsigned  equals `sat(|dx|) + sat(|dy|)`.
- `dir`  out  2  direction sector.
- `po_eol`  out  1  marks the last pixel of a gradient line.
- `po_eof`  out  1  marks the last pixel of a gradient frame.

## Operation
- A gradient frame is `(IW-2) x (IH-2)` samples, matching the Sobel valid region.
- `pi_flag` may drop at any cycle. Gaps between samples are arbitrary.
- Absolute value:
  - `ax = |dx|` and `ay = |dy|`, each `GW-1` bits.
  - The most-negative input saturates to `2^(GW-1)-1`; for `GW=12`, -2048 becomes 2047.
- Magnitude: `mag = ax + ay`. This is GW bits wide and cannot overflow.
- Direction, using the thresholds `T1=106` and `T2=618` (tan22.5 and tan67.5, scaled by 256):
  - If `256*ay <= T1*ax`, then `dir=0` (horizontal gradient). This includes `dx=dy=0`.
  - Otherwise, if `256*ay >= T2*ax`, then `dir=2` (vertical gradient).
  - Otherwise, if `dx` and `dy` have the same sign, then `dir=1` (45°).
  - Otherwise, `dir=3` (135°).
- Products are formed at full width: `GW-1+10` bits. No truncation is allowed.
- Raster counters `col` and `row`:
  - Both advance on each accepted sample.
  - `col` wraps at `IW-3`. When it wraps, `row` increments.
  - At `col==IW-3 && row==IH-3`, both clear to 0. This sample is end of frame.
- `IW` and `IH` are latched into internal registers when `col==0 && row==0` and `pi_flag=1`. Changes mid-frame have no effect.
- Minimum supported size is `IW=IH=3`, which gives a 1x1 frame: every sample carries both eol and eof.

## Timing
- Latency is 3 cycles, pipelined as follows:
  - S1 registers `ax`, `ay`, the signs and the position flags.
  - S2 registers the sum and both threshold compares.
  - S3 registers the outputs.
- Throughput is one sample per cycle. `po_flag` is `pi_flag` delayed by exactly 3 cycles.
- `po_eol` and `po_eof` are aligned with the `po_flag` of the sample they mark. Both are 0 whenever `po_flag` is 0.
- `mag`, `dir`, `po_eol` and `po_eof` hold their last values while `po_flag` is 0. `po_eol` and `po_eof` are the exception: they are forced to 0.
- Reset values:
  - `po_flag`, `po_eol`, `po_eof` = 0.
  - `mag` = 0.
  - `dir` = 0.
  - `col`, `row`, and all pipeline valids = 0.
- Reset mid-frame:
  - In-flight samples are discarded; no `po_flag` appears for them.
  - The next `pi_flag` after reset is treated as pixel (0,0).
- A sample accepted on the same cycle that `rst` is asserted is dropped.

## Configuration
- `GRAD_DIR_EN` defined: the direction logic is built as above.
- `GRAD_DIR_EN` undefined:
  - The compares and products are removed.
  - `dir` is tied to 0.
  - Magnitude, flags and latency are unchanged, still 3 cycles.

## Structure
- Shared package `canny_pkg` holds:
  - `TAN22_Q8=106` and `TAN67_Q8=618`.
  - The sector constants `DIR_H=0`, `DIR_D45=1`, `DIR_V=2`, `DIR_D135=3`.
  - The default gradient width of 12.
- One sub-module, `grad_abs_sat`: a parameterised signed-to-saturated-absolute converter. It is instantiated twice, for dx and dy.
- The raster counters and the pipeline live in the top module.

## Test plan
- `dx=100, dy=0` -> `mag=100`, `dir=0`, `po_flag` exactly 3 cycles after `pi_flag`.
- `dx=0, dy=-50` -> `mag=50`, `dir=2`. Then `dx=30, dy=30` -> `mag=60`, `dir=1`. Then `dx=30, dy=-30` -> `mag=60`, `dir=3`.
- `dx=256, dy=106` -> `dir=0` (threshold equality). Then `dx=256, dy=107` -> `dir=1`.
- `dx=-2048, dy=-2048` -> `mag=4094`, `dir=1`. With `GRAD_DIR_EN` undefined -> `dir=0`.
- `IW=6, IH=5`, 12 samples with random gaps:
  - `po_eol` on samples 4, 8 and 12.
  - `po_eof` only on sample 12.
  - A second frame restarts the count.
- Reset asserted after 5 samples of a frame, with 2 samples in flight -> no output for those 2. The next sample is treated as (0,0): `po_eol` appears on its 4th output.
